// File: rtl/airi5c_spi_sync.sv
// ----------------------------------------------------------------------------
// airi5c_spi_sync
// Two-flop synchronizer for one asynchronous SPI line, with single-cycle
// rise/fall detection on the synchronized level.
//
// Ports:
//   clk          system clock
//   n_reset      synchronous active-low reset (also driven low by enable=0)
//   reset_value  level the whole pipeline is preset to during reset, so that
//                leaving reset never produces a false edge
//   async_in     asynchronous input line
//   sync_out     synchronized level
//   rise / fall  one-cycle pulses on synchronized transitions
// ----------------------------------------------------------------------------
module airi5c_spi_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic reset_value,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    // [0] first flop, [1] synchronized level, [2] previous synchronized level
    logic [2:0] pipe_reg;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pipe_reg <= {3{reset_value}};
        end else begin
            pipe_reg <= {pipe_reg[1:0], async_in};
        end
    end

    assign sync_out = pipe_reg[1];
    assign rise     = pipe_reg[1] & ~pipe_reg[2];
    assign fall     = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/airi5c_spi_slave.sv
// ----------------------------------------------------------------------------
// airi5c_spi_slave
// SPI slave running entirely in the clk domain. sclk, ss and mosi are
// oversampled through synchronizers (sclk must be at most clk/8). Words are
// DATA_WIDTH bits, MSB first, in any of the four CPOL/CPHA modes.
//
// Ports:
//   clk, n_reset, enable     clock, sync active-low reset, block enable
//   sclk, ss, mosi           SPI bus from the master (asynchronous)
//   miso, miso_oe            SPI data to the master and its output enable
//   clk_polarity, clk_phase  CPOL / CPHA, captured while not busy
//   tx_empty, pop, data_in   TX FIFO interface (data_in taken when pop=1)
//   push, data_out           RX FIFO interface (data_out held between pushes)
//   busy                     selected (synchronized ss low)
//   underrun                 a word load found the TX FIFO empty
// ----------------------------------------------------------------------------
module airi5c_spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  enable,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic                  clk_polarity,
    input  logic                  clk_phase,
    input  logic                  tx_empty,
    output logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  underrun
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // enable=0 behaves exactly like reset
    logic run;
    assign run = n_reset & enable;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    airi5c_spi_sync u_sync_sclk (
        .clk         (clk),
        .n_reset     (run),
        .reset_value (clk_polarity),
        .async_in    (sclk),
        .sync_out    (sclk_s),
        .rise        (sclk_rise),
        .fall        (sclk_fall)
    );

    airi5c_spi_sync u_sync_ss (
        .clk         (clk),
        .n_reset     (run),
        .reset_value (1'b1),
        .async_in    (ss),
        .sync_out    (ss_s),
        .rise        (ss_rise),
        .fall        (ss_fall)
    );

    airi5c_spi_sync u_sync_mosi (
        .clk         (clk),
        .n_reset     (run),
        .reset_value (1'b0),
        .async_in    (mosi),
        .sync_out    (mosi_s),
        .rise        (mosi_rise_unused),
        .fall        (mosi_fall_unused)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_reg, state_next;
    logic                  cpol_reg, cpol_next;
    logic                  cpha_reg, cpha_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] rx_reg, rx_next;
    logic [DATA_WIDTH-1:0] tx_reg, tx_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic                  load_pend_reg, load_pend_next;   // initial load after selection
    logic                  word_done_reg, word_done_next;   // next shift edge reloads instead
    logic                  first_reg, first_next;           // CPHA=1: first leading edge of frame
    logic                  push_pend_reg, push_pend_next;   // word complete, push next cycle
    logic                  push_reg, push_next;

    logic load_now;
    logic leading_edge, trailing_edge, sample_edge, shift_edge;

    always_ff @(posedge clk) begin
        if (!run) begin
            state_reg     <= ST_IDLE;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            cnt_reg       <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            data_out_reg  <= '0;
            load_pend_reg <= 1'b0;
            word_done_reg <= 1'b0;
            first_reg     <= 1'b0;
            push_pend_reg <= 1'b0;
            push_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cpol_reg      <= cpol_next;
            cpha_reg      <= cpha_next;
            cnt_reg       <= cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            data_out_reg  <= data_out_next;
            load_pend_reg <= load_pend_next;
            word_done_reg <= word_done_next;
            first_reg     <= first_next;
            push_pend_reg <= push_pend_next;
            push_reg      <= push_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cpol_next      = cpol_reg;
        cpha_next      = cpha_reg;
        cnt_next       = cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        load_pend_next = load_pend_reg;
        word_done_next = word_done_reg;
        first_next     = first_reg;
        push_pend_next = 1'b0;
        // two-stage push: edge -> push_pend -> push/data_out
        push_next      = push_pend_reg;
        data_out_next  = push_pend_reg ? rx_reg : data_out_reg;
        load_now       = 1'b0;

        leading_edge  = cpol_reg ? sclk_fall : sclk_rise;
        trailing_edge = cpol_reg ? sclk_rise : sclk_fall;
        sample_edge   = cpha_reg ? trailing_edge : leading_edge;
        shift_edge    = cpha_reg ? leading_edge : trailing_edge;

        case (state_reg)
            ST_IDLE: begin
                // mode is tracked only while idle so it is frozen for a frame
                cpol_next = clk_polarity;
                cpha_next = clk_phase;
                if (ss_fall) begin
                    state_next     = ST_ACTIVE;
                    cnt_next       = '0;
                    rx_next        = '0;
                    tx_next        = '0;
                    load_pend_next = 1'b1;
                    word_done_next = 1'b0;
                    first_next     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    // deselect: partial word dropped, nothing loaded
                    state_next     = ST_IDLE;
                    cnt_next       = '0;
                    rx_next        = '0;
                    load_pend_next = 1'b0;
                    word_done_next = 1'b0;
                    first_next     = 1'b0;
                end else if (load_pend_reg) begin
                    load_now       = 1'b1;
                    load_pend_next = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_next = {rx_reg[DATA_WIDTH-2:0], mosi_s};
                        if (cnt_reg == LAST_BIT) begin
                            word_done_next = 1'b1;
                            push_pend_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (word_done_reg) begin
                            load_now       = 1'b1;
                            word_done_next = 1'b0;
                            cnt_next       = '0;
                        end else if (cpha_reg && first_reg) begin
                            // CPHA=1: MSB is already on miso for the first bit
                            first_next = 1'b0;
                        end else begin
                            tx_next = {tx_reg[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (load_now) begin
            tx_next = tx_empty ? '0 : data_in;
        end
    end

    assign pop      = load_now & ~tx_empty;
    assign underrun = load_now & tx_empty;
    assign busy     = (state_reg == ST_ACTIVE);
    assign miso_oe  = busy;
    assign miso     = busy & tx_reg[DATA_WIDTH-1];
    assign push     = push_reg;
    assign data_out = data_out_reg;

endmodule

// File: tb/tb_airi5c_spi_slave.sv
module tb_airi5c_spi_slave;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          n_reset, enable, sclk, ss, mosi;
    logic          miso, miso_oe, clk_polarity, clk_phase, tx_empty;
    logic          pop, push, busy, underrun;
    logic [DW-1:0] data_in, data_out;

    always #5 clk = ~clk;

    airi5c_spi_slave #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .enable       (enable),
        .sclk         (sclk),
        .ss           (ss),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .clk_polarity (clk_polarity),
        .clk_phase    (clk_phase),
        .tx_empty     (tx_empty),
        .pop          (pop),
        .data_in      (data_in),
        .push         (push),
        .data_out     (data_out),
        .busy         (busy),
        .underrun     (underrun)
    );

    // ---------------- TX FIFO model ----------------
    logic [DW-1:0] fifo_mem [16];
    int            rd_ptr = 0;
    int            wr_ptr = 0;
    logic [3:0]    rd_idx;
    assign rd_idx   = rd_ptr[3:0];
    assign tx_empty = (rd_ptr == wr_ptr);
    assign data_in  = fifo_mem[rd_idx];

    // ---------------- monitors ----------------
    int      pop_cnt = 0, push_cnt = 0, und_cnt = 0;
    longint  cyc = 0;
    bit      pop_q = 1'b0;
    logic [DW-1:0] push_data [$];
    longint        push_time [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop_q) rd_ptr <= rd_ptr + 1;
    end

    always @(negedge clk) begin
        pop_q = pop;
        if (pop === 1'b1) pop_cnt++;
        if (underrun === 1'b1) und_cnt++;
        if (push === 1'b1) begin
            push_cnt++;
            push_data.push_back(data_out);
            push_time.push_back(cyc);
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- SPI master ----------------
    logic [DW-1:0] mosi_words [4];
    logic [DW-1:0] fifo_words [4];
    logic [DW-1:0] miso_got   [4];

    task automatic half_period();
        repeat (4) @(negedge clk);
    endtask

    // One frame: nwords words (or abort_bits bits then deselect), FIFO
    // preloaded with fill words. For CPHA=0 the master deselects before
    // returning sclk to idle after the final bit.
    task automatic run_frame(input string tag, input bit cpol, input bit cpha,
                             input int nwords, input int fill, input int abort_bits);
        int p0, u0, q0, total, loads, exp_pops, w, b, idx;
        logic [31:0] obs;
        clk_polarity = cpol;
        clk_phase    = cpha;
        sclk         = cpol;
        mosi         = 1'b0;
        for (int i = 0; i < fill; i++) begin
            fifo_mem[wr_ptr[3:0]] = fifo_words[i];
            wr_ptr++;
        end
        repeat (8) @(negedge clk);
        p0 = pop_cnt; u0 = und_cnt; q0 = push_cnt;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        check($sformatf("%s_busy_on", tag), 32'(busy), 32'd1);
        check($sformatf("%s_oe_on", tag), 32'(miso_oe), 32'd1);
        total = (abort_bits > 0) ? abort_bits : nwords * DW;
        for (int k = 0; k < total; k++) begin
            w = k / DW;
            b = DW - 1 - (k % DW);
            if (!cpha) begin
                mosi = mosi_words[w][b];
                half_period();
                miso_got[w][b] = miso;
                sclk = ~cpol;
                half_period();
                if (k != total - 1) sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mosi_words[w][b];
                half_period();
                miso_got[w][b] = miso;
                sclk = cpol;
                half_period();
            end
        end
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        sclk = cpol;
        repeat (8) @(negedge clk);
        check($sformatf("%s_busy_off", tag), 32'(busy), 32'd0);
        check($sformatf("%s_oe_off", tag), 32'(miso_oe), 32'd0);
        check($sformatf("%s_miso_off", tag), 32'(miso), 32'd0);
        loads    = (abort_bits > 0) ? 1 : nwords;
        exp_pops = (loads < fill) ? loads : fill;
        check($sformatf("%s_pops", tag), 32'(pop_cnt - p0), 32'(exp_pops));
        check($sformatf("%s_underruns", tag), 32'(und_cnt - u0), 32'(loads - exp_pops));
        check($sformatf("%s_pushes", tag), 32'(push_cnt - q0), 32'((abort_bits > 0) ? 0 : nwords));
        if (abort_bits == 0) begin
            for (int i = 0; i < nwords; i++) begin
                check($sformatf("%s_miso_w%0d", tag, i), 32'(miso_got[i]),
                      (i < fill) ? 32'(fifo_words[i]) : 32'd0);
                idx = q0 + i;
                obs = (idx < push_data.size()) ? 32'(push_data[idx]) : 32'bx;
                check($sformatf("%s_rx_w%0d", tag, i), obs, 32'(mosi_words[i]));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d passed so far)", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int qb, m, n, f;
        logic [31:0] obs;

        // ---------------- reset state ----------------
        n_reset = 1'b0; enable = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        clk_polarity = 1'b0; clk_phase = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_push", 32'(push), 32'd0);
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        n_reset = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- mode 0 single word ----------------
        fifo_words[0] = 8'hA5; mosi_words[0] = 8'h3C;
        run_frame("mode0", 1'b0, 1'b0, 1, 1, 0);

        // ---------------- mode 3: idle-high sclk, no spurious edge ----------------
        qb = push_cnt;
        clk_polarity = 1'b1; sclk = 1'b1;
        repeat (16) @(negedge clk);
        check("mode3_idle_busy", 32'(busy), 32'd0);
        check("mode3_idle_push", 32'(push_cnt - qb), 32'd0);
        fifo_words[0] = 8'h81; mosi_words[0] = 8'hFF;
        run_frame("mode3", 1'b1, 1'b1, 1, 1, 0);

        // ---------------- mode 0, three words, FIFO runs dry ----------------
        fifo_words[0] = 8'h11; fifo_words[1] = 8'h22;
        for (int i = 0; i < 3; i++) mosi_words[i] = DW'($urandom);
        run_frame("mode0_x3", 1'b0, 1'b0, 3, 2, 0);

        // ---------------- mode 1 abort after 5 bits, then clean word ----------------
        fifo_words[0] = 8'hE7; mosi_words[0] = DW'($urandom);
        run_frame("mode1_abort", 1'b0, 1'b1, 1, 1, 5);
        fifo_words[0] = 8'h3D; mosi_words[0] = 8'h5A;
        run_frame("mode1_after", 1'b0, 1'b1, 1, 1, 0);

        // ---------------- reset mid-word ----------------
        clk_polarity = 1'b0; clk_phase = 1'b0; sclk = 1'b0;
        fifo_mem[wr_ptr[3:0]] = 8'h77; wr_ptr++;
        repeat (4) @(negedge clk);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'($urandom);
            half_period(); sclk = 1'b1;
            half_period(); sclk = 1'b0;
        end
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_oe", 32'(miso_oe), 32'd0);
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_push", 32'(push), 32'd0);
        check("midrst_pop", 32'(pop), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        ss = 1'b1;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (4) @(negedge clk);
        fifo_words[0] = DW'($urandom); mosi_words[0] = 8'hC3;
        run_frame("after_rst", 1'b0, 1'b0, 1, 1, 0);

        // ---------------- enable low acts as reset ----------------
        ss = 1'b0;
        repeat (8) @(negedge clk);
        check("en_busy_on", 32'(busy), 32'd1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("en_busy_off", 32'(busy), 32'd0);
        check("en_oe_off", 32'(miso_oe), 32'd0);
        ss = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- back-to-back words, push spacing ----------------
        qb = push_cnt;
        fifo_words[0] = DW'($urandom); fifo_words[1] = DW'($urandom);
        mosi_words[0] = 8'h01; mosi_words[1] = 8'h80;
        run_frame("b2b", 1'b0, 1'b0, 2, 2, 0);
        obs = (qb + 1 < push_time.size()) ? 32'(push_time[qb + 1] - push_time[qb]) : 32'bx;
        check("b2b_push_spacing", obs, 32'd64);

        // ---------------- randomized frames ----------------
        for (int r = 0; r < 4; r++) begin
            m = $urandom_range(0, 3);
            n = $urandom_range(1, 3);
            f = $urandom_range(0, n);
            for (int i = 0; i < 4; i++) begin
                mosi_words[i] = DW'($urandom);
                fifo_words[i] = DW'($urandom);
            end
            run_frame($sformatf("rand%0d_m%0d", r, m), (m & 2) != 0, (m & 1) != 0, n, f, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/airi5c_spi_slave.md
AIRI5C_SPI_SLAVE -- requirements
Module: airi5c_spi_slave

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, bits per SPI word (range 2..32).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port: n_reset  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: enable  input  1  block enable; low has the same effect as reset.
REQ-005 SHALL have port: sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-006 SHALL have port: ss  input  1  slave select, active-low, asynchronous.
REQ-007 SHALL have port: mosi  input  1  serial data from master, asynchronous.
REQ-008 SHALL have port: miso  output  1  serial data to master.
REQ-009 SHALL have port: miso_oe  output  1  miso output enable; high only while selected.
REQ-010 SHALL have port: clk_polarity  input  1  CPOL, sclk idle level.
REQ-011 SHALL have port: clk_phase  input  1  CPHA.
REQ-012 SHALL have port: tx_empty  input  1  TX FIFO empty flag.
REQ-013 SHALL have port: pop  output  1  one-cycle TX FIFO read strobe; data_in consumed in the same cycle.
REQ-014 SHALL have port: data_in  input  DATA_WIDTH  TX FIFO head word.
REQ-015 SHALL have port: push  output  1  one-cycle RX FIFO write strobe.
REQ-016 SHALL have port: data_out  output  DATA_WIDTH  received word; valid while push=1, held until next push.
REQ-017 SHALL have port: busy  output  1  high while ss is asserted (synchronized).
REQ-018 SHALL have port: underrun  output  1  one-cycle pulse when a word load finds tx_empty=1.

Function
REQ-019 SHALL pass sclk, ss and mosi through 2-flop synchronizers; edge detection uses the synchronized values; supported sclk frequency is at most clk/8.
REQ-020 SHALL treat the leading edge as the sclk transition away from clk_polarity and the trailing edge as the transition back to it.
REQ-021 SHALL act on the synchronized ss falling edge: set busy, clear bit counter and rx shift register, then load the tx buffer (pop if !tx_empty, else zeros plus underrun).
REQ-022 SHALL drive miso = tx buffer MSB and miso_oe=1 while selected; miso=0 and miso_oe=0 otherwise.
REQ-023 CPHA=0: SHALL sample mosi on each leading edge and shift the tx buffer left on each trailing edge.
REQ-024 CPHA=0: SHALL push the completed word on the leading edge of bit DATA_WIDTH-1; the following trailing edge SHALL reload the tx buffer (pop or underrun) instead of shifting and SHALL restart the bit counter.
REQ-025 CPHA=1: SHALL shift on each leading edge except the first of a word, and SHALL sample on each trailing edge.
REQ-026 CPHA=1: SHALL push on the trailing edge of bit DATA_WIDTH-1; the next leading edge SHALL reload the tx buffer instead of shifting.
REQ-027 SHALL assert push exactly 2 clk cycles after the synchronized sclk edge is detected, and SHALL NOT push again for that word.
REQ-028 SHALL abort on ss rising mid-word: discard the partial rx word (no push), clear the bit counter, and clear busy one cycle later; no pop occurs.
REQ-029 SHALL ignore sclk edges while ss is deasserted.
REQ-030 SHALL sample clk_polarity and clk_phase only while busy=0; changes during a transfer take effect at the next selection.
REQ-031 SHALL NOT pop more than once per word; pop and push in the same cycle are legal.

Reset
REQ-032 SHALL, on n_reset=0 or enable=0 at a clk edge, set pop=0, push=0, busy=0, underrun=0, miso=0, miso_oe=0, data_out=0, clear all shift registers and counters, and preset the synchronizers to ss=1 and sclk=clk_polarity.

Structure
REQ-033 SHALL contain a single sub-module, airi5c_spi_sync (2-flop synchronizer plus rise/fall detect), instanced for sclk, ss and mosi.
REQ-034 SHALL need no shared package; DATA_WIDTH is the only constant.

Verification
REQ-035 Mode 0, DATA_WIDTH=8, data_in=0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; one push with data_out=0x3C; one pop.
REQ-036 Mode 3 (CPOL=1, CPHA=1), data_in=0x81, master sends 0xFF -> miso MSB first as 0x81; push with 0xFF; sclk idles high with no spurious edge.
REQ-037 Mode 0, ss held for 3 words, TX FIFO holds 0x11, 0x22 -> miso 0x11, 0x22, 0x00; underrun pulses once; 3 pushes; 2 pops.
REQ-038 Mode 1, ss deasserted after 5 bits -> no push; busy falls; next transfer 0x5A is received intact.
REQ-039 Reset asserted mid-word, then a full mode-0 transfer of 0xC3 -> all outputs 0 during reset; 0xC3 is received correctly afterwards.
REQ-040 Back-to-back master words 0x01, 0x80 at sclk=clk/8 -> two pushes, exactly 8 sclk periods apart.
